// File: rtl/kcpsm_bus_pkg.sv
// Shared definitions for the KCPSM6-style port bus master: op codes,
// FSM state encodings, bus width and the queued command layout.
package kcpsm_bus_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_KWRITE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_RESP   = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/port_cmd_fifo.sv
// Synchronous command FIFO. The head entry is read straight from the
// storage registers, so a word pushed on an edge is visible only after it.
module port_cmd_fifo
  import kcpsm_bus_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  // Pointer update; push and pop in one cycle both advance, count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/kcpsm_port_master.sv
// Hardware initiator for the KCPSM6 port I/O bus. Runs queued WRITE, READ
// and KWRITE commands as SETUP/STROBE bus cycles, returns read data through
// a held response register and acknowledges the peripheral interrupt.
module kcpsm_port_master
  import kcpsm_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit IRQ_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [BUS_W-1:0] cmd_addr,
  input  logic [BUS_W-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BUS_W-1:0] rsp_addr,
  output logic [BUS_W-1:0] rsp_data,
  output logic             busy,
  output logic [7:0]       irq_count,
  output logic [BUS_W-1:0] port_id,
  output logic [BUS_W-1:0] out_port,
  input  logic [BUS_W-1:0] in_port,
  output logic             write_strobe,
  output logic             k_write_strobe,
  output logic             read_strobe,
  input  logic             interrupt,
  output logic             interrupt_ack
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [BUS_W-1:0] portId_q, portId_d;
  logic [BUS_W-1:0] outPort_q, outPort_d;
  logic [BUS_W-1:0] rspAddr_q, rspAddr_d;
  logic [BUS_W-1:0] rspData_q, rspData_d;
  logic [7:0]       irqCount_q, irqCount_d;

  cmd_t fifoWdata;
  cmd_t head;
  logic fifoFull;
  logic fifoEmpty;
  logic fifoPop;
  logic irqReq;
  logic atBoundary;

  assign fifoWdata = '{op: op_e'(cmd_op), addr: cmd_addr, data: cmd_wdata};
  assign irqReq    = IRQ_EN && interrupt;

  port_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (fifoWdata),
    .pop_i   (fifoPop),
    .rdata_o (head),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // State and datapath registers; reset drops any in-flight cycle and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WRITE;
      portId_q   <= '0;
      outPort_q  <= '0;
      rspAddr_q  <= '0;
      rspData_q  <= '0;
      irqCount_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      portId_q   <= portId_d;
      outPort_q  <= outPort_d;
      rspAddr_q  <= rspAddr_d;
      rspData_q  <= rspData_d;
      irqCount_q <= irqCount_d;
    end
  end

  // Next-state logic; interrupts are taken only in IDLE or between transactions.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    portId_d   = portId_q;
    outPort_d  = outPort_q;
    rspAddr_d  = rspAddr_q;
    rspData_d  = rspData_q;
    irqCount_d = irqCount_q;
    fifoPop    = 1'b0;
    atBoundary = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (irqReq) begin
          state_d = ST_ACK;
        end else if (!fifoEmpty) begin
          fifoPop = 1'b1;
          if (head.op != OP_RSVD) begin
            state_d  = ST_SETUP;
            op_d     = head.op;
            portId_d = head.addr;
            if (head.op != OP_READ) outPort_d = head.data;
          end
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        if (op_q == OP_READ) begin
          state_d   = ST_RESP;
          rspAddr_d = portId_q;
          rspData_d = in_port;
        end else begin
          atBoundary = 1'b1;
        end
      end
      ST_RESP: atBoundary = rsp_ready;
      ST_ACK: begin
        state_d    = ST_IDLE;
        irqCount_d = irqCount_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (atBoundary) begin
      if (irqReq) begin
        state_d = ST_ACK;
      end else if (!fifoEmpty && head.op != OP_RSVD) begin
        fifoPop  = 1'b1;
        state_d  = ST_SETUP;
        op_d     = head.op;
        portId_d = head.addr;
        if (head.op != OP_READ) outPort_d = head.data;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  assign cmd_ready      = !fifoFull;
  assign busy           = (state_q != ST_IDLE) || !fifoEmpty;
  assign port_id        = portId_q;
  assign out_port       = outPort_q;
  assign write_strobe   = (state_q == ST_STROBE) && (op_q == OP_WRITE);
  assign k_write_strobe = (state_q == ST_STROBE) && (op_q == OP_KWRITE);
  assign read_strobe    = (state_q == ST_STROBE) && (op_q == OP_READ);
  assign interrupt_ack  = IRQ_EN && (state_q == ST_ACK);
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_addr       = rspAddr_q;
  assign rsp_data       = rspData_q;
  assign irq_count      = irqCount_q;

endmodule

// File: tb/tb_kcpsm_port_master.sv
// Self-checking bench for kcpsm_port_master: a responder model drives in_port
// and interrupt, a scoreboard matches bus cycles and responses in order.
`timescale 1ns/1ps
module tb_kcpsm_port_master;
  import kcpsm_bus_pkg::*;

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] data;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] irq_count;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic       interrupt;
  logic       interrupt_ack;
  logic       irqRaise;

  int    errors = 0;
  int    checks = 0;
  int    cycleCnt = 0;
  int    expIrq = 0;
  item_t busQ[$];
  item_t rspQ[$];
  int    strobeTimes[$];

  kcpsm_port_master #(.FIFO_DEPTH(8), .IRQ_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_addr       (rsp_addr),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .irq_count      (irq_count),
    .port_id        (port_id),
    .out_port       (out_port),
    .in_port        (in_port),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .read_strobe    (read_strobe),
    .interrupt      (interrupt),
    .interrupt_ack  (interrupt_ack)
  );

  always #5 clk = ~clk;

  // Responder read map: switch bank at 0x01, a fixed pattern elsewhere.
  function automatic logic [7:0] respVal(input logic [7:0] a);
    if (a == 8'h01) return 8'hC3;
    return (a * 8'd7) ^ 8'h3C;
  endfunction

  // Responder: in_port registered from port_id, interrupt cleared on ack.
  always @(posedge clk) begin
    in_port <= respVal(port_id);
    if (rst) interrupt <= 1'b0;
    else if (interrupt_ack) interrupt <= 1'b0;
    else if (irqRaise) interrupt <= 1'b1;
  end

  // Scoreboard: every strobe and every consumed response is matched in order.
  task automatic monitorLoop();
    item_t exp;
    logic [1:0] obsOp;
    forever begin
      @(negedge clk);
      cycleCnt++;
      if (write_strobe || k_write_strobe || read_strobe) begin
        strobeTimes.push_back(cycleCnt);
        checks++;
        if ($countones({write_strobe, k_write_strobe, read_strobe}) != 1) begin
          errors++;
          $display("[TB] FAIL strobe_exclusive: w/k/r=%b%b%b, required one-hot", write_strobe, k_write_strobe, read_strobe);
        end
        obsOp = write_strobe ? OP_WRITE : (k_write_strobe ? OP_KWRITE : OP_READ);
        checks++;
        if (busQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_strobe: op=%0d port_id=%h, required no bus cycle", obsOp, port_id);
        end else begin
          exp = busQ.pop_front();
          if (obsOp !== exp.op || port_id !== exp.addr || (exp.op != OP_READ && out_port !== exp.data)) begin
            errors++;
            $display("[TB] FAIL bus_txn: op=%0d id=%h data=%h, required op=%0d id=%h data=%h",
                     obsOp, port_id, out_port, exp.op, exp.addr, exp.data);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (rspQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_rsp: addr=%h data=%h, required none", rsp_addr, rsp_data);
        end else begin
          exp = rspQ.pop_front();
          if (rsp_addr !== exp.addr || rsp_data !== exp.data) begin
            errors++;
            $display("[TB] FAIL rsp_txn: addr=%h data=%h, required addr=%h data=%h", rsp_addr, rsp_data, exp.addr, exp.data);
          end
        end
      end
    end
  endtask

  // Offer one command until accepted; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data);
    bit accepted = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = data;
    for (int i = 0; i < 60 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1'b1;
        if (op != OP_RSVD) busQ.push_back('{op, addr, data});
        if (op == OP_READ) rspQ.push_back('{op, addr, respVal(addr)});
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("[TB] FAIL cmd_accept: cmd_ready stayed 0 for op=%0d addr=%h, required acceptance", op, addr);
    end
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({port_id, out_port, rsp_addr, rsp_data, irq_count} !== 40'h0 ||
        {write_strobe, k_write_strobe, read_strobe, interrupt_ack, rsp_valid, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: id=%h op=%h ra=%h rd=%h irq=%h ctl=%b, required all 0",
               port_id, out_port, rsp_addr, rsp_data, irq_count,
               {write_strobe, k_write_strobe, read_strobe, interrupt_ack, rsp_valid, busy});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_timing();
    bit ok;
    applyStimulus(OP_WRITE, 8'h03, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (port_id !== 8'h03 || write_strobe !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_setup: id=%h ws=%b busy=%b, required 03/0/1", port_id, write_strobe, busy);
    end
    @(negedge clk);
    checks++;
    if (port_id !== 8'h03 || write_strobe !== 1'b1 || out_port !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL write_strobe: id=%h ws=%b data=%h, required 03/1/5A", port_id, write_strobe, out_port);
    end
    @(negedge clk);
    checks++;
    if (write_strobe !== 1'b0 || port_id !== 8'h03 || out_port !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL write_hold: ws=%b id=%h data=%h, required 0/03/5A", write_strobe, port_id, out_port);
    end
    @(posedge clk);
    #1;
    waitIdle(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL write_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_read_stall();
    bit ok;
    int seen = 0;
    rsp_ready = 1'b0;
    applyStimulus(OP_READ, 8'h01, 8'h00);
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = i;
    end
    checks++;
    if (seen != 4 || rsp_addr !== 8'h01 || rsp_data !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL read_rsp: at=%0d addr=%h data=%h, required 4/01/C3", seen, rsp_addr, rsp_data);
    end
    @(posedge clk);
    #1;
    applyStimulus(OP_WRITE, 8'h02, 8'h11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || {write_strobe, k_write_strobe, read_strobe} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL read_hold: rsp_valid=%b strobes=%b, required 1/000", rsp_valid,
                 {write_strobe, k_write_strobe, read_strobe});
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitIdle(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL read_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_irq_during_setup();
    bit ok;
    applyStimulus(OP_WRITE, 8'h20, 8'h77);
    irqRaise = 1'b1;
    @(posedge clk);
    #1;
    irqRaise = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (write_strobe !== 1'b1 || interrupt_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_strobe_first: ws=%b ack=%b, required 1/0", write_strobe, interrupt_ack);
    end
    @(negedge clk);
    checks++;
    if (interrupt_ack !== 1'b1 || write_strobe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_ack: ack=%b ws=%b, required 1/0", interrupt_ack, write_strobe);
    end
    expIrq++;
    @(negedge clk);
    checks++;
    if (interrupt_ack !== 1'b0 || irq_count !== 8'(expIrq)) begin
      errors++;
      $display("[TB] FAIL irq_count: ack=%b count=%0d, required 0/%0d", interrupt_ack, irq_count, expIrq);
    end
    @(posedge clk);
    #1;
    waitIdle(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL irq_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_irq_with_cmd();
    bit ok;
    irqRaise = 1'b1;
    applyStimulus(OP_WRITE, 8'h21, 8'h88);
    irqRaise = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (interrupt_ack !== 1'b1 || {write_strobe, k_write_strobe, read_strobe} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL irq_first_ack: ack=%b strobes=%b, required 1/000", interrupt_ack,
               {write_strobe, k_write_strobe, read_strobe});
    end
    expIrq++;
    @(negedge clk);
    checks++;
    if (interrupt_ack !== 1'b0 || irq_count !== 8'(expIrq)) begin
      errors++;
      $display("[TB] FAIL irq_first_count: ack=%b count=%0d, required 0/%0d", interrupt_ack, irq_count, expIrq);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (write_strobe !== 1'b1 || port_id !== 8'h21) begin
      errors++;
      $display("[TB] FAIL irq_then_write: ws=%b id=%h, required 1/21", write_strobe, port_id);
    end
    @(posedge clk);
    #1;
    waitIdle(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL irq_cmd_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int expGap[4] = '{2, 2, 3, 2};
    strobeTimes.delete();
    applyStimulus(OP_WRITE,  8'h04, 8'hE4);
    applyStimulus(OP_WRITE,  8'h05, 8'hE5);
    applyStimulus(OP_READ,   8'h01, 8'h00);
    applyStimulus(OP_WRITE,  8'h06, 8'hE6);
    applyStimulus(OP_KWRITE, 8'h07, 8'hE7);
    waitIdle(ok);
    checks++;
    if (!ok || strobeTimes.size() != 5) begin
      errors++;
      $display("[TB] FAIL b2b_count: strobes=%0d idle=%b, required 5/1", strobeTimes.size(), ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (strobeTimes[i+1] - strobeTimes[i] != expGap[i]) begin
          errors++;
          $display("[TB] FAIL b2b_gap%0d: gap=%0d, required %0d", i, strobeTimes[i+1] - strobeTimes[i], expGap[i]);
        end
      end
    end
  endtask

  task automatic test_reserved();
    bit ok;
    applyStimulus(OP_RSVD, 8'h44, 8'h99);
    repeat (4) @(negedge clk);
    checks++;
    if (port_id !== 8'h07 || out_port !== 8'hE7 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reserved_drop: id=%h data=%h busy=%b, required 07/E7/0", port_id, out_port, busy);
    end
    @(posedge clk);
    #1;
    applyStimulus(OP_WRITE, 8'h45, 8'h12);
    waitIdle(ok);
    checks++;
    if (!ok || port_id !== 8'h45 || out_port !== 8'h12) begin
      errors++;
      $display("[TB] FAIL reserved_after: id=%h data=%h idle=%b, required 45/12/1", port_id, out_port, ok);
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    rsp_ready = 1'b0;
    applyStimulus(OP_READ, 8'h10, 8'h00);
    for (int i = 0; i < 8; i++) applyStimulus(OP_WRITE, 8'(8'h30 + i), 8'(8'hA0 + i));
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fifo_full: cmd_ready=%b rsp_valid=%b, required 0/1", cmd_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
    fork
      applyStimulus(OP_WRITE, 8'h38, 8'hA8);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checks++;
          if (cmd_ready !== 1'b0 || {write_strobe, k_write_strobe, read_strobe} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL fifo_stall: cmd_ready=%b strobes=%b, required 0/000", cmd_ready,
                     {write_strobe, k_write_strobe, read_strobe});
          end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    waitIdle(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL fifo_drain: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    rsp_ready = 1'b1;
    applyStimulus(OP_READ,  8'h05, 8'h00);
    applyStimulus(OP_WRITE, 8'h06, 8'h66);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    busQ.delete();
    rspQ.delete();
    expIrq = 0;
    @(negedge clk);
    checks++;
    if ({write_strobe, k_write_strobe, read_strobe, interrupt_ack, rsp_valid, busy} !== 6'b0 ||
        cmd_ready !== 1'b1 || irq_count !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid: ctl=%b cmd_ready=%b irq=%0d, required 000000/1/0",
               {write_strobe, k_write_strobe, read_strobe, interrupt_ack, rsp_valid, busy}, cmd_ready, irq_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_flush: rsp_valid=%b busy=%b, required 0/0", rsp_valid, busy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Test sequence with the scoreboard running alongside.
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b1;
    irqRaise  = 1'b0;
    fork
      monitorLoop();
    join_none
    @(posedge clk);
    #1;
    test_reset();
    test_write_timing();
    test_read_stall();
    test_irq_during_setup();
    test_irq_with_cmd();
    test_back_to_back();
    test_reserved();
    test_fifo_full();
    test_reset_mid_read();
    checks++;
    if (busQ.size() != 0 || rspQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: bus left=%0d rsp left=%0d, required 0/0", busQ.size(), rspQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
